// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the TX FCS path.
package eth_pkg;

    localparam logic [31:0] ETH_CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC32_INIT    = 32'hFFFFFFFF;
    localparam int          ETH_MIN_FRAME_LEN = 64;
    localparam int          ETH_FCS_LEN       = 4;

    // TX FCS append controller states.
    typedef enum logic [1:0] {
        TX_FCS_IDLE    = 2'd0,
        TX_FCS_PAYLOAD = 2'd1,
        TX_FCS_PAD     = 2'd2,
        TX_FCS_FCS     = 2'd3
    } tx_fcs_state_e;

    // One byte on the internal/output stream.
    typedef struct packed {
        logic       user;
        logic       last;
        logic [7:0] data;
    } fcs_beat_t;

    // Select FCS byte idx (0 = first on the wire) from the running CRC register.
    function automatic logic [7:0] eth_fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] fcs;
        logic [7:0]  b;
        fcs = ~crc;
        case (idx)
            2'd0:    b = fcs[7:0];
            2'd1:    b = fcs[15:8];
            2'd2:    b = fcs[23:16];
            default: b = fcs[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational LFSR/CRC step: advances state_in by DATA_WIDTH input bits.
// REVERSE=1 gives the reflected (LSB-first) Galois form used by Ethernet.
module lfsr #(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04C11DB7,
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    REVERSE    = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);

    function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            r[i] = v[LFSR_WIDTH-1-i];
        end
        return r;
    endfunction

    localparam logic [LFSR_WIDTH-1:0] POLY_R = reflect(LFSR_POLY);

    logic fb;

    // Bit-serial Galois update unrolled across the data word.
    always_comb begin
        state_out = state_in;
        fb        = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE) begin
                fb        = state_out[0] ^ data_in[i];
                state_out = state_out >> 1;
                if (fb) state_out = state_out ^ POLY_R;
            end else begin
                fb        = state_out[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
                state_out = state_out << 1;
                if (fb) state_out = state_out ^ LFSR_POLY;
            end
        end
    end

endmodule

// File: rtl/axis_eth_fcs_append.sv
// Appends the Ethernet FCS to 8-bit AXI-Stream frames on the TX path.
// Build option: define FCS_PAD_EN to zero-pad short frames to
// MIN_FRAME_LENGTH-4 bytes before the FCS.
//
// Handshake: a byte moves on an interface only in a cycle where tvalid and
// tready are both high; a producer holds tdata/tlast/tuser stable while
// tvalid=1 and tready=0. s_axis_tready is a register loaded from the output
// stage's early-ready, so a byte accepted upstream always has a skid slot.
module axis_eth_fcs_append
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LENGTH = ETH_MIN_FRAME_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE    = TX_FCS_IDLE;
    localparam logic [1:0] ST_PAYLOAD = TX_FCS_PAYLOAD;
    localparam logic [1:0] ST_FCS     = TX_FCS_FCS;

    logic [1:0]  state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic [7:0]  crc_data;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic        tuser_q, tuser_d;
    logic        s_tready_q, s_tready_d;
    logic        busy_q, busy_d;
    logic        in_xfer;

    fcs_beat_t   int_beat;
    logic        int_tvalid;
    logic        int_ready_q, int_ready_early;

    fcs_beat_t   out_q, tmp_q;
    logic        out_valid_q, tmp_valid_q;
    logic        out_pop;

`ifdef FCS_PAD_EN
    localparam logic [1:0]  ST_PAD     = TX_FCS_PAD;
    localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LENGTH - ETH_FCS_LEN);

    logic [15:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
`else
    logic unused_min_len;
    assign unused_min_len = ^MIN_FRAME_LENGTH;
`endif

    assign in_xfer         = s_axis_tvalid & s_tready_q;
    assign out_pop         = out_valid_q & m_axis_tready;
    // Safe to accept next cycle if downstream drains now or both slots are empty.
    assign int_ready_early = m_axis_tready | (~out_valid_q & ~tmp_valid_q);

    lfsr #(
        .LFSR_WIDTH(32),
        .LFSR_POLY (ETH_CRC32_POLY),
        .DATA_WIDTH(8),
        .REVERSE   (1'b1)
    ) u_crc (
        .data_in  (crc_data),
        .state_in (crc_q),
        .state_out(crc_next)
    );

    // Frame FSM: pass payload, optionally pad, then emit the four FCS bytes.
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        fcs_idx_d  = fcs_idx_q;
        tuser_d    = tuser_q;
        s_tready_d = 1'b0;
        int_beat   = '0;
        int_tvalid = 1'b0;
        crc_data   = s_axis_tdata;
`ifdef FCS_PAD_EN
        byte_cnt_d = byte_cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_PAYLOAD: begin
                s_tready_d    = int_ready_early;
                int_beat.data = s_axis_tdata;
                int_tvalid    = in_xfer;
                if (in_xfer) begin
                    crc_d   = crc_next;
                    state_d = ST_PAYLOAD;
`ifdef FCS_PAD_EN
                    byte_cnt_d = byte_cnt_inc;
`endif
                    if (s_axis_tlast) begin
                        tuser_d    = s_axis_tuser;
                        s_tready_d = 1'b0;
                        fcs_idx_d  = 2'd0;
                        state_d    = ST_FCS;
`ifdef FCS_PAD_EN
                        if (byte_cnt_inc < PAD_TARGET) state_d = ST_PAD;
`endif
                    end
                end
            end
`ifdef FCS_PAD_EN
            ST_PAD: begin
                crc_data   = 8'h00;
                int_tvalid = int_ready_q;
                if (int_ready_q) begin
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_inc;
                    if (byte_cnt_inc == PAD_TARGET) state_d = ST_FCS;
                end
            end
`endif
            ST_FCS: begin
                int_tvalid    = int_ready_q;
                int_beat.data = eth_fcs_byte(crc_q, fcs_idx_q);
                int_beat.last = (fcs_idx_q == 2'd3);
                int_beat.user = (fcs_idx_q == 2'd3) & tuser_q;
                if (int_ready_q) begin
                    fcs_idx_d = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        state_d    = ST_IDLE;
                        crc_d      = ETH_CRC32_INIT;
                        s_tready_d = int_ready_early;
`ifdef FCS_PAD_EN
                        byte_cnt_d = 16'd0;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Busy spans first accepted byte to the last FCS byte leaving the block.
    always_comb begin
        busy_d = busy_q;
        if (out_pop && out_q.last) busy_d = 1'b0;
        if (state_q == ST_IDLE && in_xfer) busy_d = 1'b1;
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            crc_q       <= ETH_CRC32_INIT;
            fcs_idx_q   <= 2'd0;
            tuser_q     <= 1'b0;
            s_tready_q  <= 1'b0;
            busy_q      <= 1'b0;
            int_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            fcs_idx_q   <= fcs_idx_d;
            tuser_q     <= tuser_d;
            s_tready_q  <= s_tready_d;
            busy_q      <= busy_d;
            int_ready_q <= int_ready_early;
        end
    end

`ifdef FCS_PAD_EN
    // Saturating frame byte counter (payload plus pad).
    always_ff @(posedge clk) begin
        if (rst) byte_cnt_q <= 16'd0;
        else     byte_cnt_q <= byte_cnt_d;
    end
`endif

    // Two-entry output skid: head register drives the port, temp catches one stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            tmp_q       <= '0;
            out_valid_q <= 1'b0;
            tmp_valid_q <= 1'b0;
        end else if (out_pop) begin
            if (tmp_valid_q) begin
                out_q       <= tmp_q;
                out_valid_q <= 1'b1;
                tmp_valid_q <= int_tvalid;
                if (int_tvalid) tmp_q <= int_beat;
            end else begin
                out_valid_q <= int_tvalid;
                if (int_tvalid) out_q <= int_beat;
            end
        end else if (int_tvalid) begin
            if (!out_valid_q) begin
                out_q       <= int_beat;
                out_valid_q <= 1'b1;
            end else begin
                tmp_q       <= int_beat;
                tmp_valid_q <= 1'b1;
            end
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tuser  = out_q.user;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_eth_fcs_append.sv
// Testbench for axis_eth_fcs_append (either FCS_PAD_EN build).
module tb_axis_eth_fcs_append;

  localparam int MIN_LEN = 64;
  localparam int RDY_LIM = 2000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_axis_tdata  = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tlast  = 1'b0;
  logic       s_axis_tuser  = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       m_axis_tready = 1'b0;
  logic       busy;

  axis_eth_fcs_append #(.MIN_FRAME_LENGTH(MIN_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .busy         (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: {user, last, data}
  logic [9:0] exp_q[$];
  bit         ready_rand  = 1'b0;
  bit         mon_ignore  = 1'b0;
  bit         saw_tlast   = 1'b0;
  bit         was_stalled = 1'b0;
  logic [9:0] held        = '0;
  logic [9:0] beat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference CRC-32, byte at a time
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] pl[$], input bit user);
    logic [31:0] c;
    int          n;
    c = 32'hFFFFFFFF;
    n = pl.size();
    foreach (pl[i]) begin
      exp_q.push_back({2'b00, pl[i]});
      c = crc_upd(c, pl[i]);
    end
`ifdef FCS_PAD_EN
    while (n < MIN_LEN - 4) begin
      exp_q.push_back(10'h000);
      c = crc_upd(c, 8'h00);
      n++;
    end
`endif
    c = ~c;
    exp_q.push_back({2'b00, c[7:0]});
    exp_q.push_back({2'b00, c[15:8]});
    exp_q.push_back({2'b00, c[23:16]});
    exp_q.push_back({user, 1'b1, c[31:24]});
  endtask

  // monitor + downstream ready driver
  always @(negedge clk) begin
    if (was_stalled)
      check("hold", {21'h0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {21'h0, 1'b1, held});
    m_axis_tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    was_stalled   = m_axis_tvalid && !m_axis_tready && !rst && !mon_ignore;
    held          = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready && !rst) begin
      if (mon_ignore) begin
        if (m_axis_tlast) saw_tlast = 1'b1;
      end else if (exp_q.size() == 0) begin
        check("extra_beat", 32'd1, 32'd0);
      end else begin
        beat = exp_q.pop_front();
        check("out_beat", {22'h0, held}, {22'h0, beat});
      end
    end
  end

  // driver: call at a negedge; returns at the negedge after acceptance
  task automatic drive_byte(input logic [7:0] d, input bit last, input bit user);
    int guard;
    guard = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && guard < RDY_LIM) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(guard < RDY_LIM), 32'd1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input bit user, input bit gaps);
    for (int i = 0; i < pl.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      drive_byte(pl[i], i == pl.size() - 1, user && (i == pl.size() - 1));
      if (i == 0) check("busy_set", 32'(busy), 32'd1);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    int         len;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    check("rst_m_tuser",  32'(m_axis_tuser),  32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: "123456789", FCS bytes 26 39 F4 CB
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
`ifdef FCS_PAD_EN
    push_exp(pl, 1'b0);
`else
    foreach (pl[i]) exp_q.push_back({2'b00, pl[i]});
    exp_q.push_back(10'h026);
    exp_q.push_back(10'h039);
    exp_q.push_back(10'h0F4);
    exp_q.push_back(10'h1CB);
`endif
    send_frame(pl, 1'b0, 1'b0);
    wait_drain();

    // 2: 14-byte frame
    pl = {};
    for (int i = 0; i < 14; i++) pl.push_back(8'hA0 + 8'(i));
    push_exp(pl, 1'b0);
    send_frame(pl, 1'b0, 1'b0);
    wait_drain();

    // 3: 60-byte frame (no pad), then 1-byte frame
    pl = {};
    for (int i = 0; i < 60; i++) pl.push_back(8'(i * 7 + 3));
    push_exp(pl, 1'b0);
    send_frame(pl, 1'b0, 1'b0);
    pl = {8'h5A};
    push_exp(pl, 1'b0);
    send_frame(pl, 1'b0, 1'b0);
    wait_drain();

    // 5: tuser on last byte of a 20-byte frame
    pl = {};
    for (int i = 0; i < 20; i++) pl.push_back(8'hFF - 8'(i));
    push_exp(pl, 1'b1);
    send_frame(pl, 1'b1, 1'b0);
    wait_drain();

    // 4: random downstream ready and input gaps
    ready_rand = 1'b1;
    for (int f = 0; f < 200; f++) begin
      pl  = {};
      len = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
      push_exp(pl, ($urandom_range(0, 7) == 0));
      send_frame(pl, exp_q[exp_q.size()-1][9], 1'b1);
    end
    wait_drain();
    ready_rand = 1'b0;
    @(negedge clk);

    // 6: reset at payload byte 10, then a clean 64-byte frame
    mon_ignore = 1'b1;
    for (int i = 0; i < 10; i++) drive_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_busy",     32'(busy),          32'd0);
    check("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_tlast", 32'(saw_tlast), 32'd0);
    mon_ignore = 1'b0;
    pl = {};
    for (int i = 0; i < 60; i++) pl.push_back(8'(i + 100));
    push_exp(pl, 1'b0);
    send_frame(pl, 1'b0, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
